// File: rtl/par_circ_fifo_pkg.sv
// buf_pkg: circular-pointer wrap helper and read-stride clamp for par_circ_fifo
package buf_pkg;

  function automatic int circ_add(int ptr, int inc, int mem_size);
    int s;
    s = ptr + inc;
    return (s >= mem_size) ? s - mem_size : s;
  endfunction

  function automatic int stride_clamp(int stride, int par_read);
    return (stride == 0 || stride > par_read) ? par_read : stride;
  endfunction

endpackage

// File: rtl/par_circ_fifo_if.sv
// par_circ_fifo_if: producer/consumer handshake bundle; rd_stride only with BUF_STRIDE_EN
interface par_circ_fifo_if #(
  parameter int SIZE      = 16,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 2,
  parameter int CNT_W     = 4
);
  logic                      flush;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [SIZE*PAR_WRITE-1:0] din;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [SIZE*PAR_READ-1:0]  dout;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic                      empty;
`ifdef BUF_STRIDE_EN
  logic [CNT_W-1:0]          rd_stride;
`endif
  modport master (
    output flush, wr_valid, din, rd_ready,
`ifdef BUF_STRIDE_EN
    output rd_stride,
`endif
    input  wr_ready, rd_valid, dout, count, full, empty
  );
  modport slave (
    input  flush, wr_valid, din, rd_ready,
`ifdef BUF_STRIDE_EN
    input  rd_stride,
`endif
    output wr_ready, rd_valid, dout, count, full, empty
  );
endinterface

// File: rtl/par_circ_fifo_circ_ptr.sv
// circ_ptr: modulo-MEM_SIZE pointer advancing by a variable amount, with flush
module circ_ptr
  import buf_pkg::*;
#(
  parameter int MEM_SIZE = 8,
  parameter int ADDR_W   = 3,
  parameter int INC_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              en,
  input  logic [INC_W-1:0]  inc,
  output logic [ADDR_W-1:0] ptr
);
  // flush outranks advance; wrap by single conditional subtract
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (flush) ptr <= '0;
    else if (en) ptr <= ADDR_W'(circ_add(int'(ptr), int'(inc), MEM_SIZE));
endmodule

// File: rtl/par_circ_fifo.sv
// par_circ_fifo: circular buffer, PAR_WRITE words in / PAR_READ words out per transfer; BUF_STRIDE_EN enables rd_stride
module par_circ_fifo
  import buf_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int MEM_SIZE  = 8,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 2,
  parameter int ADDR_W    = $clog2(MEM_SIZE),
  parameter int CNT_W     = $clog2(MEM_SIZE + 1)
) (
  input logic           clk,
  input logic           rst,
  par_circ_fifo_if.slave b
);
  logic [SIZE-1:0]   mem [MEM_SIZE];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0]  count, released;
  logic              wfire, rfire;

  assign b.wr_ready = int'(count) <= MEM_SIZE - PAR_WRITE;
  assign b.rd_valid = int'(count) >= PAR_READ;
  assign b.full     = int'(count) == MEM_SIZE;
  assign b.empty    = count == '0;
  assign b.count    = count;
  assign wfire      = b.wr_valid & b.wr_ready;
  assign rfire      = b.rd_valid & b.rd_ready;
`ifdef BUF_STRIDE_EN
  assign released   = CNT_W'(stride_clamp(int'(b.rd_stride), PAR_READ));
`else
  assign released   = CNT_W'(PAR_READ);
`endif

  circ_ptr #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .INC_W(CNT_W)) u_wptr (
    .clk(clk), .rst(rst), .flush(b.flush), .en(wfire), .inc(CNT_W'(PAR_WRITE)), .ptr(wptr)
  );
  circ_ptr #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .INC_W(CNT_W)) u_rptr (
    .clk(clk), .rst(rst), .flush(b.flush), .en(rfire), .inc(released), .ptr(rptr)
  );

  // occupancy: add written, subtract released; flush clears
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (b.flush) count <= '0;
    else count <= count + (wfire ? CNT_W'(PAR_WRITE) : '0) - (rfire ? released : '0);

  // store write lanes, wrapping past the end of the array
  always_ff @(posedge clk)
    if (wfire && !b.flush)
      for (int k = 0; k < PAR_WRITE; k++)
        mem[ADDR_W'(circ_add(int'(wptr), k, MEM_SIZE))] <= b.din[k*SIZE +: SIZE];

  for (genvar j = 0; j < PAR_READ; j++) begin : g_rd
    assign b.dout[j*SIZE +: SIZE] = mem[ADDR_W'(circ_add(int'(rptr), j, MEM_SIZE))];
  end
endmodule

// File: tb/tb_par_circ_fifo.sv
// tb_par_circ_fifo: queue-model check of par_circ_fifo; stride scenario when BUF_STRIDE_EN is defined
module tb_par_circ_fifo;
  localparam int SIZE = 16, MEM_SIZE = 8, PW = 4, PR = 2;
  localparam int CNT_W = $clog2(MEM_SIZE + 1);

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  par_circ_fifo_if #(.SIZE(SIZE), .PAR_WRITE(PW), .PAR_READ(PR), .CNT_W(CNT_W)) b ();
  par_circ_fifo #(.SIZE(SIZE), .MEM_SIZE(MEM_SIZE), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk(clk), .rst(rst), .b(b)
  );

  int tests = 0, fails = 0;
  logic [SIZE-1:0] q[$];

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [SIZE*PW-1:0] lanes(int base);
    logic [SIZE*PW-1:0] d;
    for (int k = 0; k < PW; k++) d[k*SIZE +: SIZE] = SIZE'(base + k);
    return d;
  endfunction

  function automatic int pair(int lo);
    return ((lo + 1) << 16) | lo;
  endfunction

  task automatic compare();
    int n;
    n = q.size();
    chk("count", int'(b.count), n);
    chk("full", int'(b.full), int'(n == MEM_SIZE));
    chk("empty", int'(b.empty), int'(n == 0));
    chk("wr_ready", int'(b.wr_ready), int'(n <= MEM_SIZE - PW));
    chk("rd_valid", int'(b.rd_valid), int'(n >= PR));
    if (n >= PR)
      for (int j = 0; j < PR; j++) chk("dout_lane", int'(b.dout[j*SIZE +: SIZE]), int'(q[j]));
  endtask

  task automatic step(bit wv, bit rr, bit fl, logic [SIZE*PW-1:0] d, int stride);
    int n, rel;
    bit wf, rf;
    b.wr_valid = wv;
    b.rd_ready = rr;
    b.flush    = fl;
    b.din      = d;
`ifdef BUF_STRIDE_EN
    b.rd_stride = CNT_W'(stride);
    rel = (stride == 0 || stride > PR) ? PR : stride;
`else
    rel = PR + 0 * stride;
`endif
    n  = q.size();
    wf = wv && n <= MEM_SIZE - PW;
    rf = rr && n >= PR;
    if (fl) q.delete();
    else begin
      if (rf) repeat (rel) void'(q.pop_front());
      if (wf) for (int k = 0; k < PW; k++) q.push_back(d[k*SIZE +: SIZE]);
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    b.wr_valid = 0; b.rd_ready = 0; b.flush = 0; b.din = '0;
`ifdef BUF_STRIDE_EN
    b.rd_stride = '0;
`endif
    #1 rst = 1;
    #2;
    chk("rst_count", int'(b.count), 0);
    chk("rst_empty", int'(b.empty), 1);
    chk("rst_full", int'(b.full), 0);
    chk("rst_wr_ready", int'(b.wr_ready), 1);
    chk("rst_rd_valid", int'(b.rd_valid), 0);
    @(negedge clk);
    rst = 0;
    // fill and drain
    step(1, 0, 0, lanes(0), 0);
    step(1, 0, 0, lanes(4), 0);
    chk("fill_count", int'(b.count), 8);
    chk("fill_full", int'(b.full), 1);
    chk("fill_wr_ready", int'(b.wr_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout", int'(b.dout), pair(2 * i));
      step(0, 1, 0, '0, 0);
    end
    chk("drain_empty", int'(b.empty), 1);
    // wrap
    step(1, 0, 0, lanes(0), 0);
    step(0, 1, 0, '0, 0);
    step(1, 0, 0, lanes(4), 0);
    step(0, 1, 0, '0, 0);
    step(1, 0, 0, lanes(8), 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_dout", int'(b.dout), pair(4 + 2 * i));
      step(0, 1, 0, '0, 0);
    end
    // concurrent write and read
    step(1, 0, 0, lanes(0), 0);
    step(1, 1, 0, lanes(20), 0);
    chk("conc_count", int'(b.count), 6);
    chk("conc_dout", int'(b.dout), pair(2));
    // flush wins over fires
    step(1, 1, 1, lanes(40), 0);
    chk("flush_count", int'(b.count), 0);
    chk("flush_empty", int'(b.empty), 1);
    step(1, 0, 0, lanes(50), 0);
    chk("post_flush_dout", int'(b.dout), pair(50));
    step(0, 0, 1, '0, 0);
`ifdef BUF_STRIDE_EN
    step(1, 0, 0, lanes(0), 0);
    for (int i = 0; i < 3; i++) begin
      chk("stride_dout", int'(b.dout), pair(i));
      step(0, 1, 0, '0, 1);
    end
    chk("stride_count", int'(b.count), 1);
    chk("stride_rd_valid", int'(b.rd_valid), 0);
`endif
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
           {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
           int'($urandom_range(0, 3)));
    // asynchronous reset mid-operation
    step(1, 0, 0, lanes(60), 0);
    rst = 1;
    #1;
    chk("async_rst_count", int'(b.count), 0);
    chk("async_rst_empty", int'(b.empty), 1);
    chk("async_rst_rd_valid", int'(b.rd_valid), 0);
    q.delete();
    #1 rst = 0;
    step(0, 0, 0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
